// File: rtl/frame_pixel_responder.sv
// Pixel-read responder: (x,y) -> linear address -> one fixed-latency memory read; waitrequest low for one RESP cycle at T+3+MEM_LATENCY.
// Stalls in ISSUE while mem_busy; optional last-hit cache under FRAME_PIXEL_RESPONDER_HIT_CACHE_EN (T+1 response on hit).
module frame_pixel_responder #(
    parameter int COL_NUM     = 640,
    parameter int ROW_NUM     = 480,
    parameter int ADDR_W      = 19,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [9:0]        req_x,
    input  logic [9:0]        req_y,
    output logic              waitrequest,
    output logic [7:0]        pixel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_busy,
    input  logic [7:0]        mem_rdata,
    output logic              err_range
);

    typedef enum logic [2:0] {IDLE, ADDR, ISSUE, WAIT, RESP} state_t;

    localparam logic [10:0] COL_LIM = 11'(COL_NUM);
    localparam logic [10:0] ROW_LIM = 11'(ROW_NUM);
    localparam logic [3:0]  LAT_M1  = 4'(MEM_LATENCY - 1);

    state_t            state_q;
    logic [9:0]        x_q;
    logic [9:0]        y_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        cnt_q;
    logic [7:0]        pixel_q;
    logic              err_q;
    logic              out_of_range;

    // Constant-coefficient multiply unrolled into shifted adds of y, one per set bit of COL_NUM.
    function automatic logic [ADDR_W-1:0] lin_addr(input logic [9:0] x, input logic [9:0] y);
        logic [ADDR_W-1:0] acc;
        logic [ADDR_W-1:0] yw;
        acc = ADDR_W'(x);
        yw  = ADDR_W'(y);
        for (int b = 0; b < ADDR_W; b++) begin
            if (COL_NUM[b]) acc = acc + (yw << b);
        end
        return acc;
    endfunction

    assign out_of_range = ({1'b0, x_q} >= COL_LIM) || ({1'b0, y_q} >= ROW_LIM);

`ifdef FRAME_PIXEL_RESPONDER_HIT_CACHE_EN
    logic       c_vld_q;
    logic [9:0] c_x_q;
    logic [9:0] c_y_q;
    logic [7:0] c_pix_q;
    logic       cache_hit;

    assign cache_hit = c_vld_q && (req_x == c_x_q) && (req_y == c_y_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            c_vld_q <= 1'b0;
            c_x_q   <= '0;
            c_y_q   <= '0;
            c_pix_q <= '0;
        end else if (state_q == WAIT && cnt_q == 4'd0) begin
            c_vld_q <= 1'b1;
            c_x_q   <= x_q;
            c_y_q   <= y_q;
            c_pix_q <= mem_rdata;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            pixel_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        x_q <= req_x;
                        y_q <= req_y;
`ifdef FRAME_PIXEL_RESPONDER_HIT_CACHE_EN
                        if (cache_hit) begin
                            pixel_q <= c_pix_q;
                            state_q <= RESP;
                        end else begin
                            state_q <= ADDR;
                        end
`else
                        state_q <= ADDR;
`endif
                    end
                end
                ADDR: begin
                    if (out_of_range) begin
                        err_q   <= 1'b1;
                        pixel_q <= '0;
                        state_q <= RESP;
                    end else begin
                        addr_q  <= lin_addr(x_q, y_q);
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!mem_busy) begin
                        cnt_q   <= LAT_M1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        pixel_q <= mem_rdata;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // A core that has dropped its request is never stalled, even mid-transaction.
    assign waitrequest = req_valid && (state_q != RESP);
    assign mem_rd      = (state_q == ISSUE);
    assign mem_addr    = addr_q;
    assign pixel       = pixel_q;
    assign err_range   = err_q;

endmodule
